bounded_lock_rr_arbiter: RTL and testbench

//  Round-robin arbiter for NoC router output/VC allocation with packet locking.
//  A winner that asserts hold_in keeps the grant across flits.
//  The lock is bounded by a beat limit, and an urgent request class is added.

---
 rtl/bounded_lock_rr_arbiter.sv | 118 +++++++++++
 tb/tb_bounded_lock_rr_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/bounded_lock_rr_arbiter.sv
// Round-robin arbiter with packet locking for a NoC switch allocator.
// A winner holding hold_in keeps the grant for up to MAX_HOLD consumed beats; urgent requests win the RR scan.
module bounded_lock_rr_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int MAX_HOLD       = 16,
  parameter int ID_W           = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic [NUM_REQUESTERS-1:0] hold_in,
  input  logic [NUM_REQUESTERS-1:0] urgent,
  input  logic                      enable,
  output logic [NUM_REQUESTERS-1:0] grant_oh,
  output logic                      grant_valid,
  output logic [ID_W-1:0]           grant_id,
  output logic                      locked,
  output logic                      hold_expired
);

  localparam int N     = NUM_REQUESTERS;
  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(MAX_HOLD);
  localparam bit               BOUNDED = (MAX_HOLD != 0);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            fsm_q, fsm_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   last_id_q, last_id_d;
  logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic              hold_expired_q, hold_expired_d;

  logic [N-1:0]      cand;
  logic [ID_W-1:0]   scan_idx;
  logic [ID_W-1:0]   win_idx;
  logic              win_found;
  logic              beat;
  logic [CNT_W-1:0]  next_cnt;

  // Winner selection: locked owner only, else RR scan starting after last_id.
  always_comb begin
    cand      = ((request & urgent) != '0) ? (request & urgent) : request;
    scan_idx  = '0;
    win_idx   = '0;
    win_found = 1'b0;
    if (fsm_q == LOCKED) begin
      win_idx   = owner_q;
      win_found = request[owner_q];
    end else begin
      for (int k = 1; k <= N; k++) begin
        scan_idx = ID_W'((int'(last_id_q) + k) % N);
        if (!win_found && cand[scan_idx]) begin
          win_found = 1'b1;
          win_idx   = scan_idx;
        end
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    if (win_found) grant_oh[win_idx] = 1'b1;
    grant_valid = win_found;
    grant_id    = win_found ? win_idx : '0;
  end

  always_comb begin
    fsm_d          = fsm_q;
    owner_d        = owner_q;
    last_id_d      = last_id_q;
    hold_cnt_d     = hold_cnt_q;
    hold_expired_d = 1'b0;
    beat           = win_found & enable;
    // Counter saturates rather than wrapping; only reachable when unbounded.
    if (fsm_q == LOCKED)
      next_cnt = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + 1'b1;
    else
      next_cnt = CNT_W'(1);
    if (beat) begin
      last_id_d = win_idx;
      if (hold_in[win_idx]) begin
        if (BOUNDED && next_cnt == LIMIT) begin
          fsm_d          = IDLE;
          hold_cnt_d     = '0;
          hold_expired_d = 1'b1;
        end else begin
          fsm_d      = LOCKED;
          owner_d    = win_idx;
          hold_cnt_d = next_cnt;
        end
      end else begin
        fsm_d      = IDLE;
        hold_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm_q          <= IDLE;
      owner_q        <= '0;
      last_id_q      <= ID_W'(N - 1);
      hold_cnt_q     <= '0;
      hold_expired_q <= 1'b0;
    end else begin
      fsm_q          <= fsm_d;
      owner_q        <= owner_d;
      last_id_q      <= last_id_d;
      hold_cnt_q     <= hold_cnt_d;
      hold_expired_q <= hold_expired_d;
    end
  end

  assign locked       = (fsm_q == LOCKED);
  assign hold_expired = hold_expired_q;

endmodule

// File: tb/tb_bounded_lock_rr_arbiter.sv
// Bench for bounded_lock_rr_arbiter: directed scenarios then random traffic,
// every cycle compared against a rule-level reference model.
module tb_bounded_lock_rr_arbiter;

  localparam int N    = 4;
  localparam int MAXH = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] request, hold_in, urgent;
  logic         enable;
  logic [N-1:0] grant_oh;
  logic         grant_valid;
  logic [1:0]   grant_id;
  logic         locked, hold_expired;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit m_locked;
  int m_owner;
  int m_last;
  int m_cnt;
  bit m_exp;

  bounded_lock_rr_arbiter #(.NUM_REQUESTERS(N), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .reset(reset), .request(request), .hold_in(hold_in),
    .urgent(urgent), .enable(enable), .grant_oh(grant_oh),
    .grant_valid(grant_valid), .grant_id(grant_id), .locked(locked),
    .hold_expired(hold_expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_winner(input logic [N-1:0] req, input logic [N-1:0] urg);
    logic [N-1:0] c;
    if (m_locked) return req[m_owner] ? m_owner : -1;
    c = ((req & urg) != 0) ? (req & urg) : req;
    for (int k = 1; k <= N; k++) begin
      if (c[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_last = N - 1; m_cnt = 0; m_exp = 0;
  endtask

  task automatic model_step(input logic [N-1:0] req, input logic [N-1:0] hold,
                            input logic [N-1:0] urg, input logic en);
    int w;
    int c;
    w = model_winner(req, urg);
    m_exp = 0;
    if (w >= 0 && en) begin
      m_last = w;
      if (hold[w]) begin
        c = m_locked ? m_cnt + 1 : 1;
        if (c == MAXH) begin
          m_locked = 0; m_cnt = 0; m_exp = 1;
        end else begin
          m_locked = 1; m_owner = w; m_cnt = c;
        end
      end else begin
        m_locked = 0; m_cnt = 0;
      end
    end
  endtask

  // One clock: drive, check at negedge, advance model at posedge.
  // exp_id: >=0 directed grant id, -1 directed no-grant, -2 model only.
  task automatic cycle(input logic [N-1:0] req, input logic [N-1:0] hold,
                       input logic [N-1:0] urg, input logic en, input logic rst_n,
                       input int exp_id);
    int w;
    logic [N-1:0] oh;
    request = req; hold_in = hold; urgent = urg; enable = en; reset = rst_n;
    @(negedge clk);
    w  = model_winner(req, urg);
    oh = '0;
    if (w >= 0) oh[w] = 1'b1;
    chk("grant_oh", grant_oh, oh);
    chk("grant_valid", grant_valid, w >= 0);
    chk("grant_id", grant_id, (w >= 0) ? w : 0);
    chk("locked", locked, m_locked);
    chk("hold_expired", hold_expired, m_exp);
    if (exp_id >= 0) chk("dir_id", {grant_valid, grant_id}, {1'b1, 2'(exp_id)});
    else if (exp_id == -1) chk("dir_none", grant_valid, 1'b0);
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(req, hold, urg, en);
    #1;
  endtask

  initial begin
    request = '0; hold_in = '0; urgent = '0; enable = 1'b0; reset = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;

    // T1: plain rotation
    begin
      int ids [5] = '{0, 1, 2, 3, 0};
      foreach (ids[i]) cycle(4'hF, 4'h0, 4'h0, 1'b1, 1'b1, ids[i]);
    end
    // T2: lock on 1 for 3 hold beats then tail
    for (int i = 0; i < 3; i++) cycle(4'hF, 4'b0010, 4'h0, 1'b1, 1'b1, 1);
    chk("t2_locked", locked, 1'b1);
    cycle(4'hF, 4'h0, 4'h0, 1'b1, 1'b1, 1);
    cycle(4'hF, 4'h0, 4'h0, 1'b1, 1'b1, 2);
    // T3: limit release after MAX_HOLD beats of requester 2
    cycle(4'b0010, 4'h0, 4'h0, 1'b1, 1'b1, 1);
    for (int i = 0; i < 4; i++) cycle(4'hF, 4'b0100, 4'h0, 1'b1, 1'b1, 2);
    chk("t3_expired", hold_expired, 1'b1);
    chk("t3_unlocked", locked, 1'b0);
    cycle(4'hF, 4'b0100, 4'h0, 1'b1, 1'b1, 3);
    chk("t3_pulse_end", hold_expired, 1'b0);
    // T4: urgent class, then urgent ignored while locked
    cycle(4'b0001, 4'h0, 4'h0, 1'b1, 1'b1, 0);
    for (int i = 0; i < 3; i++) cycle(4'hF, 4'h0, 4'b1000, 1'b1, 1'b1, 3);
    cycle(4'b0010, 4'b0010, 4'h0, 1'b1, 1'b1, 1);
    for (int i = 0; i < 2; i++) cycle(4'hF, 4'b0010, 4'b1000, 1'b1, 1'b1, 1);
    cycle(4'hF, 4'h0, 4'b1000, 1'b1, 1'b1, 1);
    // T5: stalls and owner bubble freeze the lock; expiry shows count frozen
    cycle(4'hF, 4'b0100, 4'h0, 1'b1, 1'b1, 2);
    for (int i = 0; i < 3; i++) begin
      cycle(4'hF, 4'b0100, 4'h0, 1'b0, 1'b1, 2);
      chk("t5_oh", grant_oh, 4'b0100);
    end
    cycle(4'b1011, 4'b0100, 4'h0, 1'b1, 1'b1, -1);
    chk("t5_locked", locked, 1'b1);
    cycle(4'hF, 4'b0100, 4'h0, 1'b1, 1'b1, 2);
    cycle(4'hF, 4'b0100, 4'h0, 1'b1, 1'b1, 2);
    chk("t5_still_locked", locked, 1'b1);
    cycle(4'hF, 4'b0100, 4'h0, 1'b1, 1'b1, 2);
    chk("t5_expired", hold_expired, 1'b1);
    // T6: reset mid-lock with hold_cnt=3
    for (int i = 0; i < 3; i++) cycle(4'hF, 4'b1000, 4'h0, 1'b1, 1'b1, 3);
    cycle(4'hF, 4'b1000, 4'h0, 1'b1, 1'b0, 3);
    chk("t6_locked", locked, 1'b0);
    cycle(4'hF, 4'h0, 4'h0, 1'b1, 1'b1, 0);

    // random traffic, long-hold bias to exercise locks and limit
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r, h, u;
      r = 4'($urandom_range(0, 15));
      h = ($urandom_range(0, 2) != 0) ? 4'hF : 4'($urandom_range(0, 15));
      u = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      cycle(r, h, u, $urandom_range(0, 3) != 0, $urandom_range(0, 59) != 0, -2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
